// File: rtl/pio_irq_servicer_if.sv
// Avalon-style slave bus between the irq servicer and one edge-capture PIO.
// The master side drives the access; the slave side answers with readdata.
interface pio_irq_servicer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface

// File: rtl/pio_irq_servicer.sv
// Autonomous servicer for an edge-capture PIO: programs the irq mask once,
// then on each irq reads/clears the capture register and reports the pin value.
module pio_irq_servicer #(
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] MASK_VALUE   = 32'h1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             irq,
  pio_irq_servicer_if.master bus,
  output logic             event_valid,
  output logic             event_data,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] spurious_count,
  output logic             busy
);

  typedef enum logic [3:0] {
    INIT_WAIT = 4'd0,
    INIT_WR   = 4'd1,
    IDLE      = 4'd2,
    RD_CAP    = 4'd3,
    WAIT_CAP  = 4'd4,
    CLR       = 4'd5,
    RD_DAT    = 4'd6,
    WAIT_DAT  = 4'd7,
    REPORT    = 4'd8
  } state_t;

  localparam logic [1:0]       LAST_WAIT = 2'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic             cap_q, cap_d;
  logic [1:0]       address_q, address_d;
  logic             chipselect_q, chipselect_d;
  logic             write_n_q, write_n_d;
  logic [31:0]      writedata_q, writedata_d;
  logic             event_valid_q, event_valid_d;
  logic             event_data_q, event_data_d;
  logic [CNT_W-1:0] event_count_q, event_count_d;
  logic [CNT_W-1:0] spurious_count_q, spurious_count_d;
  logic             busy_q, busy_d;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= INIT_WAIT;
      wait_cnt_q       <= 2'd0;
      cap_q            <= 1'b0;
      address_q        <= 2'd0;
      chipselect_q     <= 1'b0;
      write_n_q        <= 1'b1;
      writedata_q      <= 32'd0;
      event_valid_q    <= 1'b0;
      event_data_q     <= 1'b0;
      event_count_q    <= '0;
      spurious_count_q <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      cap_q            <= cap_d;
      address_q        <= address_d;
      chipselect_q     <= chipselect_d;
      write_n_q        <= write_n_d;
      writedata_q      <= writedata_d;
      event_valid_q    <= event_valid_d;
      event_data_q     <= event_data_d;
      event_count_q    <= event_count_d;
      spurious_count_q <= spurious_count_d;
      busy_q           <= busy_d;
    end
  end

  // Next state, sampled read results and counters; bus outputs decode state_d
  // so the registered strobes line up with the state they belong to.
  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = 2'd0;
    cap_d            = cap_q;
    event_data_d     = event_data_q;
    event_count_d    = event_count_q;
    spurious_count_d = spurious_count_q;
    address_d        = address_q;
    chipselect_d     = 1'b0;
    write_n_d        = 1'b1;
    writedata_d      = writedata_q;

    case (state_q)
      INIT_WAIT: begin
        if (enable) state_d = INIT_WR;
        else        state_d = INIT_WAIT;
      end
      INIT_WR: state_d = IDLE;
      IDLE: begin
        if (irq && enable) state_d = RD_CAP;
        else               state_d = IDLE;
      end
      RD_CAP: state_d = WAIT_CAP;
      WAIT_CAP: begin
        if (wait_cnt_q == LAST_WAIT) begin
          cap_d   = (bus.readdata != 32'd0);
          state_d = CLR;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      CLR: begin
        if (!cap_q) begin
          spurious_count_d = (spurious_count_q == CNT_MAX) ? spurious_count_q
                                                           : spurious_count_q + CNT_ONE;
          state_d = IDLE;
        end else begin
          state_d = RD_DAT;
        end
      end
      RD_DAT: state_d = WAIT_DAT;
      WAIT_DAT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          event_data_d = bus.readdata[0];
          state_d      = REPORT;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      REPORT: begin
        event_count_d = (event_count_q == CNT_MAX) ? event_count_q
                                                   : event_count_q + CNT_ONE;
        state_d = IDLE;
      end
      default: state_d = INIT_WAIT;
    endcase

    case (state_d)
      INIT_WR: begin
        chipselect_d = 1'b1;
        write_n_d    = 1'b0;
        address_d    = 2'd2;
        writedata_d  = MASK_VALUE;
      end
      RD_CAP: begin
        chipselect_d = 1'b1;
        address_d    = 2'd3;
      end
      WAIT_CAP: address_d = 2'd3;
      CLR: begin
        chipselect_d = 1'b1;
        write_n_d    = 1'b0;
        address_d    = 2'd3;
        writedata_d  = 32'hFFFF_FFFF;
      end
      RD_DAT: begin
        chipselect_d = 1'b1;
        address_d    = 2'd0;
      end
      WAIT_DAT: address_d = 2'd0;
      default: begin
        chipselect_d = 1'b0;
        write_n_d    = 1'b1;
      end
    endcase

    event_valid_d = (state_d == REPORT);
    busy_d        = !((state_d == IDLE) || (state_d == INIT_WAIT));
  end

  assign bus.address    = address_q;
  assign bus.chipselect = chipselect_q;
  assign bus.write_n    = write_n_q;
  assign bus.writedata  = writedata_q;
  assign event_valid    = event_valid_q;
  assign event_data     = event_data_q;
  assign event_count    = event_count_q;
  assign spurious_count = spurious_count_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_pio_irq_servicer.sv
// Directed bench for pio_irq_servicer: a small PIO model answers the bus and a
// scoreboard queue holds the pin value each serviced edge must report.
module tb_pio_irq_servicer;
  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        irq;
  logic        event_valid, event_data, busy;
  logic [15:0] event_count, spurious_count;

  pio_irq_servicer_if bus ();

  pio_irq_servicer #(.READ_LATENCY(RL), .MASK_VALUE(32'h1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq), .bus(bus),
    .event_valid(event_valid), .event_data(event_data), .event_count(event_count),
    .spurious_count(spurious_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // PIO model: data reg = pin, edge capture set by set_cap, write-1-to-clear.
  logic        pin = 1'b1;
  logic        set_cap = 1'b0;
  logic        set_spur = 1'b0;
  logic [31:0] mask_r, cap_r;
  logic        spur_r;
  logic [31:0] rd_pipe [0:RL-1];
  logic [31:0] rd_val;

  always_comb begin
    case (bus.address)
      2'd0: rd_val = {31'd0, pin};
      2'd2: rd_val = mask_r;
      2'd3: rd_val = cap_r;
      default: rd_val = 32'd0;
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= 32'd0;
      cap_r  <= 32'd0;
      spur_r <= 1'b0;
      for (int i = 0; i < RL; i++) rd_pipe[i] <= 32'd0;
    end else begin
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2) mask_r <= bus.writedata;
      if (bus.chipselect && !bus.write_n && bus.address == 2'd3) begin
        cap_r  <= cap_r & ~bus.writedata;
        spur_r <= 1'b0;
      end
      if (set_cap)  cap_r[0] <= 1'b1;
      if (set_spur) spur_r <= 1'b1;
      rd_pipe[0] <= (bus.chipselect && bus.write_n) ? rd_val : 32'hDEAD_BEEF;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign bus.readdata = rd_pipe[RL-1];
  assign irq = spur_r | (|(cap_r & mask_r));

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   bus_cnt = 0, wr_cnt = 0, ev_cnt = 0, last_wr_cyc = -1;
  logic [1:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  logic        exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus activity log and scoreboard pop on every reported event.
  always @(negedge clk) begin
    if (bus.chipselect) bus_cnt++;
    if (bus.chipselect && !bus.write_n) begin
      wr_cnt++;
      last_wr_cyc  = cyc;
      last_wr_addr = bus.address;
      last_wr_data = bus.writedata;
    end
    if (event_valid) begin
      ev_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_event", 64'd1, 64'd0);
      else                   chk("sb_event_data", {63'd0, event_data}, {63'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full sequence from T0 to T0+5+2*RL; drop_at lowers enable at that step.
  task automatic service(input logic pin_v, input bit raise, input int drop_at, input int exp_cnt);
    if (raise) begin
      pin = pin_v;
      set_cap = 1'b1;
    end
    exp_q.push_back(pin_v);
    if (raise) begin
      @(negedge clk);
      set_cap = 1'b0;
    end
    for (int k = 1; k <= 5 + 2*RL; k++) begin
      @(negedge clk);
      if (k == drop_at) enable = 1'b0;
      if (k == 1)
        chk("rd_cap", {bus.chipselect, bus.write_n, bus.address}, {1'b1, 1'b1, 2'd3});
      else if (k <= 1 + RL)
        chk("wait_cap", {bus.chipselect, bus.write_n, bus.address}, {1'b0, 1'b1, 2'd3});
      else if (k == 2 + RL)
        chk("clr_write", {bus.chipselect, bus.write_n, bus.address, bus.writedata},
            {1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF});
      else if (k == 3 + RL)
        chk("rd_dat", {bus.chipselect, bus.write_n, bus.address}, {1'b1, 1'b1, 2'd0});
      else if (k <= 3 + 2*RL)
        chk("wait_dat", {bus.chipselect, bus.write_n, bus.address, event_valid},
            {1'b0, 1'b1, 2'd0, 1'b0});
      else if (k == 4 + 2*RL)
        chk("report", {event_valid, event_data, busy}, {1'b1, pin_v, 1'b1});
      else
        chk("after_report", {event_valid, busy, event_count}, {1'b0, 1'b0, 16'(exp_cnt)});
    end
  endtask

  int snap, ev0, wr0, rel;

  initial begin
    irq_init_wait();
    // Reset state.
    chk("reset_outputs", {bus.address, bus.chipselect, bus.write_n, bus.writedata,
        event_valid, event_data, busy}, {2'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0});
    chk("reset_counts", {event_count, spurious_count}, 32'd0);
    rel = cyc;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("init_write_count", 64'(wr_cnt), 64'd1);
    chk("init_write_cycle", 64'(last_wr_cyc), 64'(rel + 1));
    chk("init_write_val", {last_wr_addr, last_wr_data}, {2'd2, 32'h1});
    chk("init_bus_quiet", 64'(bus_cnt), 64'd1);

    // Pin 1->0, normal service.
    service(1'b0, 1'b1, -1, 1);

    // Spurious irq with capture reading 0.
    ev0 = ev_cnt;
    set_spur = 1'b1;
    @(negedge clk);
    set_spur = 1'b0;
    for (int k = 1; k <= 4 + RL; k++) begin
      @(negedge clk);
      if (k == 1)
        chk("sp_rd_cap", {bus.chipselect, bus.write_n, bus.address}, {1'b1, 1'b1, 2'd3});
      else if (k == 2 + RL)
        chk("sp_clr", {bus.chipselect, bus.write_n, bus.address}, {1'b1, 1'b0, 2'd3});
      else if (k > 2 + RL)
        chk("sp_idle", {bus.chipselect, busy}, {1'b0, 1'b0});
    end
    chk("sp_count", 64'(spurious_count), 64'd1);
    chk("sp_no_event", 64'(ev_cnt - ev0), 64'd0);

    // Three back-to-back edges, each 2 cycles after the previous REPORT.
    for (int i = 0; i < 3; i++) service(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1, -1, 2 + i);
    chk("three_edges_count", 64'(event_count), 64'd4);

    // enable dropped at T2; sequence completes, next irq waits for enable.
    service(1'b1, 1'b1, 2, 5);
    pin = 1'b0;
    set_cap = 1'b1;
    @(negedge clk);
    set_cap = 1'b0;
    snap = bus_cnt;
    repeat (5) @(negedge clk);
    chk("disabled_no_bus", 64'(bus_cnt - snap), 64'd0);
    chk("disabled_idle", {irq, busy}, {1'b1, 1'b0});
    enable = 1'b1;
    service(1'b0, 1'b0, -1, 6);

    // Reset pulsed during WAIT_DAT.
    pin = 1'b1;
    set_cap = 1'b1;
    exp_q.push_back(1'b1);
    @(negedge clk);
    set_cap = 1'b0;
    repeat (4 + RL) @(negedge clk);
    chk("pre_reset_wait_dat", {bus.chipselect, bus.address, busy}, {1'b0, 2'd0, 1'b1});
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", {bus.address, bus.chipselect, bus.write_n, bus.writedata,
        event_valid, event_data, busy}, {2'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0});
    chk("midrst_counts", {event_count, spurious_count}, 32'd0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    wr0 = wr_cnt;
    rel = cyc;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("reinit_write_count", 64'(wr_cnt - wr0), 64'd1);
    chk("reinit_write_cycle", 64'(last_wr_cyc), 64'(rel + 1));
    chk("reinit_write_val", {last_wr_addr, last_wr_data}, {2'd2, 32'h1});
    service(1'b0, 1'b1, -1, 1);
    chk("post_reset_spurious", 64'(spurious_count), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic irq_init_wait();
    repeat (3) @(negedge clk);
  endtask

endmodule
